fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DB_CYCLES, default 20'd1_000_000; consecutive synchronized-high cycles that qualify a press.
REQ-002 Parameter REFRESH_BITS, default 18; width of the display refresh counter.
REQ-003 Port clk  input  1  system clock; all logic on its rising edge.
REQ-004 Port clr  input  1  reset, synchronous, active-high.
REQ-005 Port button_red  input  1  raw, bouncy, asynchronous read push-button.
REQ-006 Port empty  input  1  FIFO empty flag.
REQ-007 Port r_data  input  8  FIFO head word, valid combinationally while empty=0.
REQ-008 Port rd  output  1  one-cycle FIFO pop strobe.
REQ-009 Port an  output  4  digit anodes, active-low.
REQ-010 Port sseg  output  8  segments, active-low; sseg[7]=dp, sseg[6:0]=g..a.
REQ-011 Port data_valid  output  1  high once at least one word has been read since reset.
REQ-012 Port underflow  output  1  sticky: a press arrived while empty=1.

Function
REQ-013 button_red SHALL pass a 2-flop synchronizer before any other use.
REQ-014 Debounce FSM states SHALL be IDLE, WAIT1, HELD, WAIT0.
REQ-015 IDLE->WAIT1 on sync=1; WAIT1->HELD after DB_CYCLES consecutive sync=1 cycles; WAIT1->IDLE on any sync=0.
REQ-016 HELD->WAIT0 on sync=0; WAIT0->IDLE after DB_CYCLES consecutive sync=0 cycles; WAIT0->HELD on any sync=1.
REQ-017 The WAIT1->HELD transition SHALL produce exactly one internal press pulse; holding the button produces no repeat.
REQ-018 On a press with empty=0, rd SHALL assert for exactly the following cycle, and r_data SHALL be captured into the display register on that same edge.
REQ-019 On a press with empty=1, rd SHALL stay 0 and the display register and count SHALL be unchanged.
REQ-020 Read count SHALL be 8 bits, incremented per issued rd, wrapping 8'hFF->8'h00.
REQ-021 Digits 1:0 SHALL show the captured byte in hex; digits 3:2 SHALL show the read count in hex.
REQ-022 The top 2 refresh-counter bits SHALL select the digit 0..3; exactly one an bit is low at any time.
REQ-023 The hex decoder SHALL cover 0-F; dp SHALL always be 1.
REQ-024 data_valid SHALL rise with the first rd and stay high until reset.

Reset
REQ-025 With clr=1 at an edge: FSM=IDLE, counters=0, display register=8'h00, count=0, rd=0, data_valid=0, underflow=0.
REQ-026 After reset: an=4'b1110, sseg=8'b1100_0000 (digit '0').
REQ-027 A reset during WAIT1 or HELD SHALL discard the press; no rd follows the reset.

Configuration
REQ-028 Macro FIFO_READER_UNDERFLOW_EN defined: underflow sets on REQ-019 condition and clears only by clr.
REQ-029 Macro FIFO_READER_UNDERFLOW_EN undefined: underflow tied to 0, no flag register synthesized.

Structure
REQ-030 Package fifo_reader_pkg SHALL hold the debounce state enum, the 7-segment hex constants, and the anode patterns.
REQ-031 The debouncer SHALL be sub-module btn_debounce (ports clk, clr, btn_in, press), instantiated once.

Verification (DB_CYCLES=4, REFRESH_BITS=4)
REQ-032 Glitches of 4 ns, 8 ns, 8 ns, then a clean 100-cycle hold with empty=0 and r_data=8'hA5 -> exactly one rd pulse; digits show A,5,0,1.
REQ-033 Two presses on a model FIFO holding 8'h01 then 8'h04 -> two rd pulses; final digits 0,4,0,2; data_valid=1.
REQ-034 Press with empty=1 -> rd stays 0; display unchanged; underflow=1 with the macro, 0 without.
REQ-035 256 presses with empty=0 -> count wraps to 8'h00; digits 3:2 show 0,0.
REQ-036 clr pulse while in HELD -> all REQ-025/026 values; releasing and re-pressing yields exactly one rd.
REQ-037 Free run 64 cycles -> an cycles 1110,1101,1011,0111 every 4 cycles; never two an bits low.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO reader: debounce states,
// active-low 7-segment glyphs (g..a) and active-low anode patterns.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    HELD  = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  localparam logic [6:0] SEG_0 = 7'b100_0000;
  localparam logic [6:0] SEG_1 = 7'b111_1001;
  localparam logic [6:0] SEG_2 = 7'b010_0100;
  localparam logic [6:0] SEG_3 = 7'b011_0000;
  localparam logic [6:0] SEG_4 = 7'b001_1001;
  localparam logic [6:0] SEG_5 = 7'b001_0010;
  localparam logic [6:0] SEG_6 = 7'b000_0010;
  localparam logic [6:0] SEG_7 = 7'b111_1000;
  localparam logic [6:0] SEG_8 = 7'b000_0000;
  localparam logic [6:0] SEG_9 = 7'b001_0000;
  localparam logic [6:0] SEG_A = 7'b000_1000;
  localparam logic [6:0] SEG_B = 7'b000_0011;
  localparam logic [6:0] SEG_C = 7'b100_0110;
  localparam logic [6:0] SEG_D = 7'b010_0001;
  localparam logic [6:0] SEG_E = 7'b000_0110;
  localparam logic [6:0] SEG_F = 7'b000_1110;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG3 = 4'b0111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes a raw push-button and debounces it with a 4-state FSM;
// emits a single-cycle press pulse when a press is qualified.
module btn_debounce
  import fifo_reader_pkg::*;
#(
  parameter logic [19:0] DB_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_in,
  output logic press
);

  localparam logic [19:0] LAST_CNT = DB_CYCLES - 20'd1;

  logic        sync_ff1;
  logic        sync_ff2;
  db_state_t   state;
  db_state_t   state_next;
  logic [19:0] cnt;
  logic [19:0] cnt_next;
  logic        press_next;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync_ff1 <= btn_in;
      sync_ff2 <= sync_ff1;
      state    <= state_next;
      cnt      <= cnt_next;
      press    <= press_next;
    end
  end

  // Any sample disagreeing with the level being qualified restarts the run.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    press_next = 1'b0;
    case (state)
      IDLE: begin
        if (sync_ff2) begin
          state_next = WAIT1;
          cnt_next   = '0;
        end
      end
      WAIT1: begin
        if (!sync_ff2) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == LAST_CNT) begin
          state_next = HELD;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + 20'd1;
        end
      end
      HELD: begin
        if (!sync_ff2) begin
          state_next = WAIT0;
          cnt_next   = '0;
        end
      end
      WAIT0: begin
        if (sync_ff2) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt == LAST_CNT) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 20'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/fifo_reader.sv
// Pops one FIFO word per debounced button press and shows the last word and
// the read count on a 4-digit multiplexed display.
// Optional macro FIFO_READER_UNDERFLOW_EN enables the sticky underflow flag.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter logic [19:0] DB_CYCLES    = 20'd1_000_000,
  parameter int          REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       button_red,
  input  logic       empty,
  input  logic [7:0] r_data,
  output logic       rd,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       data_valid,
  output logic       underflow
);

  logic                    press;
  logic [7:0]              disp_reg;
  logic [7:0]              read_cnt;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [1:0]              digit_sel;
  logic [3:0]              nibble;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .clr   (clr),
    .btn_in(button_red),
    .press (press)
  );

  // A press against an empty FIFO is dropped; otherwise capture and pop together.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd          <= 1'b0;
      disp_reg    <= 8'h00;
      read_cnt    <= 8'h00;
      data_valid  <= 1'b0;
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
      rd          <= press & ~empty;
      if (press && !empty) begin
        disp_reg   <= r_data;
        read_cnt   <= read_cnt + 8'd1;
        data_valid <= 1'b1;
      end
    end
  end

`ifdef FIFO_READER_UNDERFLOW_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      underflow <= 1'b0;
    end else if (press && empty) begin
      underflow <= 1'b1;
    end
  end
`else
  assign underflow = 1'b0;
`endif

  assign digit_sel = refresh_cnt[REFRESH_BITS-1 -: 2];

  always_comb begin
    an     = AN_DIG0;
    nibble = disp_reg[3:0];
    case (digit_sel)
      2'd0: begin
        an     = AN_DIG0;
        nibble = disp_reg[3:0];
      end
      2'd1: begin
        an     = AN_DIG1;
        nibble = disp_reg[7:4];
      end
      2'd2: begin
        an     = AN_DIG2;
        nibble = read_cnt[3:0];
      end
      default: begin
        an     = AN_DIG3;
        nibble = read_cnt[7:4];
      end
    endcase
  end

  assign sseg = {1'b1, hex_to_seg(nibble)};

endmodule

// File: tb/tb_fifo_reader.sv
// Directed self-checking bench for fifo_reader with a short debounce window
// and a small array-backed model FIFO driving empty/r_data.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       clr;
  logic       button_red;
  logic       empty;
  logic [7:0] r_data;
  logic       rd;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       data_valid;
  logic       underflow;

  logic [7:0] fifo_mem [512];
  int         wr_idx = 0;
  int         rd_idx = 0;

  int   err_count = 0;
  int   chk_count = 0;
  int   rd_pulses = 0;
  int   rd_long   = 0;
  logic rd_prev   = 1'b0;
  int   base;
  logic uf_exp;

  fifo_reader #(
    .DB_CYCLES   (20'd4),
    .REFRESH_BITS(4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .button_red(button_red),
    .empty     (empty),
    .r_data    (r_data),
    .rd        (rd),
    .an        (an),
    .sseg      (sseg),
    .data_valid(data_valid),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  assign empty  = (rd_idx == wr_idx);
  assign r_data = fifo_mem[rd_idx % 512];

  // Pops happen mid-cycle, after the DUT has already captured the head word.
  always @(negedge clk) begin
    if (rd) begin
      rd_pulses++;
      if (rd_prev) rd_long++;
      if (rd_idx != wr_idx) rd_idx++;
    end
    rd_prev = rd;
  end

  function automatic logic [6:0] exp_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] val);
    fifo_mem[wr_idx % 512] = val;
    wr_idx++;
  endtask

  task automatic applyStimulus(input int hold, input int gap);
    button_red = 1'b1;
    repeat (hold) @(negedge clk);
    button_red = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic doReset();
    clr        = 1'b1;
    button_red = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rd"}, {31'd0, rd}, 32'd0);
    checkOutput({tag, "_dv"}, {31'd0, data_valid}, 32'd0);
    checkOutput({tag, "_uf"}, {31'd0, underflow}, 32'd0);
    checkOutput({tag, "_an"}, {28'd0, an}, 32'hE);
    checkOutput({tag, "_sseg"}, {24'd0, sseg}, 32'hC0);
  endtask

  task automatic checkDigits(input string tag, input logic [7:0] disp, input logic [7:0] cnt);
    logic [3:0] want_an;
    logic [3:0] nib;
    int waited;
    for (int d = 0; d < 4; d++) begin
      want_an = ~(4'b0001 << d);
      case (d)
        0: nib = disp[3:0];
        1: nib = disp[7:4];
        2: nib = cnt[3:0];
        default: nib = cnt[7:4];
      endcase
      waited = 0;
      while (an !== want_an && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 40)
        checkOutput($sformatf("%s_an_wait%0d", tag, d), {28'd0, an}, {28'd0, want_an});
      else
        checkOutput($sformatf("%s_digit%0d", tag, d), {24'd0, sseg}, {24'd0, 1'b1, exp_seg(nib)});
    end
  endtask

  initial begin
    logic [3:0] an_exp;
    `ifdef FIFO_READER_UNDERFLOW_EN
    uf_exp = 1'b1;
    `else
    uf_exp = 1'b0;
    `endif

    // Reset values, then free-running digit scan.
    clr        = 1'b1;
    button_red = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    clr = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      an_exp = ~(4'b0001 << ((k % 16) >> 2));
      checkOutput("an_scan", {28'd0, an}, {28'd0, an_exp});
      checkOutput("an_one_low", $countones(~an), 32'd1);
    end

    // Glitches are rejected; a clean long hold yields one read.
    push(8'hA5);
    base = rd_pulses;
    @(negedge clk); #3 button_red = 1'b1; #4 button_red = 1'b0;
    repeat (6) @(negedge clk); #1 button_red = 1'b1; #8 button_red = 1'b0;
    repeat (6) @(negedge clk); #1 button_red = 1'b1; #8 button_red = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("glitch_no_rd", rd_pulses - base, 32'd0);
    applyStimulus(100, 20);
    checkOutput("hold_one_rd", rd_pulses - base, 32'd1);
    checkOutput("hold_dv", {31'd0, data_valid}, 32'd1);
    checkDigits("a5", 8'hA5, 8'h01);

    // Two presses against the model FIFO.
    doReset();
    push(8'h01);
    push(8'h04);
    base = rd_pulses;
    applyStimulus(10, 12);
    checkDigits("first", 8'h01, 8'h01);
    applyStimulus(10, 12);
    checkOutput("two_rd", rd_pulses - base, 32'd2);
    checkOutput("two_dv", {31'd0, data_valid}, 32'd1);
    checkOutput("two_uf", {31'd0, underflow}, 32'd0);
    checkDigits("second", 8'h04, 8'h02);

    // Press while empty.
    base = rd_pulses;
    applyStimulus(10, 12);
    checkOutput("empty_no_rd", rd_pulses - base, 32'd0);
    checkOutput("empty_uf", {31'd0, underflow}, {31'd0, uf_exp});
    checkDigits("empty", 8'h04, 8'h02);

    // Count wrap after 256 reads.
    doReset();
    for (int i = 0; i < 256; i++) push(i[7:0]);
    base = rd_pulses;
    for (int i = 0; i < 256; i++) applyStimulus(10, 12);
    checkOutput("wrap_rd", rd_pulses - base, 32'd256);
    checkOutput("wrap_dv", {31'd0, data_valid}, 32'd1);
    checkDigits("wrap", 8'hFF, 8'h00);

    // Reset while HELD, then a fresh press.
    push(8'h3C);
    push(8'h5A);
    base = rd_pulses;
    button_red = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("held_rd", rd_pulses - base, 32'd1);
    clr        = 1'b1;
    button_red = 1'b0;
    repeat (4) @(negedge clk);
    checkReset("held_clr");
    clr = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("held_after_clr", rd_pulses - base, 32'd1);
    applyStimulus(10, 12);
    checkOutput("repress_rd", rd_pulses - base, 32'd2);
    checkDigits("repress", 8'h5A, 8'h01);

    // Reset during WAIT1 discards the pending press.
    push(8'h77);
    base = rd_pulses;
    button_red = 1'b1;
    repeat (4) @(negedge clk);
    clr        = 1'b1;
    button_red = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("wait1_clr_no_rd", rd_pulses - base, 32'd0);
    checkDigits("wait1_clr", 8'h00, 8'h00);

    checkOutput("rd_single_cycle", rd_long, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_count, chk_count);
    $finish;
  end

endmodule
